// File: rtl/feature_map_writer.sv
// Feature-map writer: per-kernel 2-deep result FIFOs drained in strict kernel
// order into a linear output RAM, one OUTPUT_SIZE-word region per kernel.

module fmw_lane #(
  parameter int DATA_WIDTH = 32,
  parameter int CW         = 2
) (
  input  logic                  clock_i,
  input  logic                  reset_ni,
  input  logic                  clear,
  input  logic                  run,
  input  logic                  run_next,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  pop,
  input  logic                  inc,
  output logic                  nonempty,
  output logic [DATA_WIDTH-1:0] head,
  output logic [CW-1:0]         cnt,
  output logic                  ovf,
  output logic                  hold
);
  logic [DATA_WIDTH-1:0] e0, e1;
  logic [1:0]            occ, occ_nx;
  logic                  push;

  assign push     = run && !clear && valid;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign ovf      = push && !pop && (occ == 2'd2);
  assign nonempty = (occ != 2'd0);
  assign head     = e0;

  always_comb begin
    occ_nx = occ;
    if (clear)                                 occ_nx = 2'd0;
    else if (push && !pop && (occ != 2'd2))    occ_nx = occ + 2'd1;
    else if (pop && !push)                     occ_nx = occ - 2'd1;
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      e0   <= '0;
      e1   <= '0;
      occ  <= '0;
      cnt  <= '0;
      hold <= 1'b1;
    end else begin
      occ  <= occ_nx;
      hold <= !run_next || (occ_nx != 2'd0);
      if (clear)    cnt <= '0;
      else if (inc) cnt <= cnt + CW'(1);
      if (!clear) begin
        if (pop) begin
          e0 <= (push && (occ == 2'd1)) ? data : e1;
          if (push && (occ == 2'd2)) e1 <= data;
        end else if (push) begin
          if (occ == 2'd0)      e0 <= data;
          else if (occ == 2'd1) e1 <= data;
        end
      end
    end
  end
endmodule

module feature_map_writer #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int N_KERNELS   = 64,
  parameter int OUTPUT_SIZE = 16,
  parameter int BASE_ADDR   = 0
) (
  input  logic                                 clock_i,
  input  logic                                 reset_ni,
  input  logic                                 start_i,
  input  logic [N_KERNELS-1:0]                 data_valid_i,
  input  logic [N_KERNELS-1:0][DATA_WIDTH-1:0] data_i,
  output logic [N_KERNELS-1:0]                 hold_data_o,
  output logic                                 wren_o,
  output logic [ADDR_WIDTH-1:0]                wraddress_o,
  output logic [DATA_WIDTH-1:0]                wrdata_o,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 overflow_o
);
  localparam int PW    = (N_KERNELS > 1) ? $clog2(N_KERNELS) : 1;
  localparam int CW    = $clog2(OUTPUT_SIZE + 1);
  localparam int TOTAL = N_KERNELS * OUTPUT_SIZE;
  localparam int TW    = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;

  logic [PW-1:0]                         ptr;
  logic [TW-1:0]                         total;
  logic [N_KERNELS-1:0]                  nonempty, pop, inc, ovf;
  logic [N_KERNELS-1:0][DATA_WIDTH-1:0]  head;
  logic [N_KERNELS-1:0][CW-1:0]          cnt;
  logic                                  run, run_next, pop_fire, write_fire, last_write;
  logic [ADDR_WIDTH-1:0]                 addr;

  assign run        = (state == RUN);
  assign run_next   = (state_nx == RUN);
  // start_i restarts the frame, so nothing drains on that edge.
  assign pop_fire   = run && !start_i && nonempty[ptr];
  // A kernel whose region is already full has its word discarded.
  assign write_fire = pop_fire && (cnt[ptr] != CW'(OUTPUT_SIZE));
  assign last_write = write_fire && (total == TW'(TOTAL - 1));
  assign addr       = ADDR_WIDTH'(BASE_ADDR + int'(ptr) * OUTPUT_SIZE + int'(cnt[ptr]));
  assign busy_o     = run;
  assign done_o     = (state == DONE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_i) state_nx = RUN;
      RUN:     if (!start_i && last_write) state_nx = DONE;
      DONE:    if (start_i) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) state <= IDLE;
    else           state <= state_nx;
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ptr         <= '0;
      total       <= '0;
      overflow_o  <= 1'b0;
      wren_o      <= 1'b0;
      wraddress_o <= '0;
      wrdata_o    <= '0;
    end else begin
      wren_o <= write_fire;
      if (write_fire) begin
        wraddress_o <= addr;
        wrdata_o    <= head[ptr];
      end
      if (start_i) begin
        ptr        <= '0;
        total      <= '0;
        overflow_o <= 1'b0;
      end else begin
        if (pop_fire)   ptr   <= (ptr == PW'(N_KERNELS - 1)) ? '0 : ptr + PW'(1);
        if (write_fire) total <= total + TW'(1);
        if (|ovf)       overflow_o <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < N_KERNELS; k++) begin : g_lane
    assign pop[k] = pop_fire   && (ptr == PW'(k));
    assign inc[k] = write_fire && (ptr == PW'(k));

    fmw_lane #(.DATA_WIDTH(DATA_WIDTH), .CW(CW)) u_lane (
      .clock_i  (clock_i),
      .reset_ni (reset_ni),
      .clear    (start_i),
      .run      (run),
      .run_next (run_next),
      .valid    (data_valid_i[k]),
      .data     (data_i[k]),
      .pop      (pop[k]),
      .inc      (inc[k]),
      .nonempty (nonempty[k]),
      .head     (head[k]),
      .cnt      (cnt[k]),
      .ovf      (ovf[k]),
      .hold     (hold_data_o[k])
    );
  end
endmodule

// File: doc/feature_map_writer.md
FEATURE_MAP_WRITER -- requirements
Module: feature_map_writer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16: RAM write address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: result word width.
REQ-003 SHALL have parameter N_KERNELS, default 64: number of parallel result streams.
REQ-004 SHALL have parameter OUTPUT_SIZE, default 16: values per kernel per frame.
REQ-005 SHALL have parameter BASE_ADDR, default 0: RAM address of kernel 0, value 0.
REQ-006 SHALL have one clock and an asynchronous active-low reset: clock_i input 1 (rising-edge clock) and reset_ni input 1 (async, active low).
REQ-007 SHALL have ports start_i (input, 1, arms a frame) and data_valid_i[N_KERNELS] (input, 1 each, conv result valid per kernel).
REQ-008 SHALL have port data_i[N_KERNELS] (input, DATA_WIDTH each, conv result per kernel).
REQ-009 SHALL have port hold_data_o[N_KERNELS] (output, 1 each, backpressure to the conv core).
REQ-010 SHALL have ports wren_o (output, 1) and wraddress_o (output, ADDR_WIDTH) for the output RAM write strobe and address.
REQ-011 SHALL have port wrdata_o (output, DATA_WIDTH): output RAM write data.
REQ-012 SHALL have ports busy_o (output, 1, frame in progress), done_o (output, 1, frame complete, sticky) and overflow_o (output, 1, sticky drop flag).

Function
REQ-013 SHALL implement FSM IDLE, RUN, DONE; IDLE->RUN on start_i; RUN->DONE when total writes reach N_KERNELS*OUTPUT_SIZE; DONE->RUN on start_i.
REQ-014 SHALL, on entry to RUN, clear all per-kernel buffers, write counters, overflow_o and the kernel pointer (set to 0).
REQ-015 SHALL hold a 2-entry FIFO per kernel; in RUN, data_valid_i[k]=1 pushes data_i[k] on the clock edge.
REQ-016 SHALL register hold_data_o[k]=1 whenever FIFO k holds >=1 entry after the edge, or the state is not RUN.
REQ-017 SHALL, on a push to a full FIFO k, drop the word, leave the FIFO unchanged and set overflow_o=1 until the next start_i or reset.
REQ-018 SHALL ignore data_valid_i in IDLE and DONE; no push and no overflow.
REQ-019 SHALL drain in strict kernel order: pointer p waits on kernel p until FIFO p is non-empty, then writes one word and advances p to p+1, wrapping from N_KERNELS-1 to 0.
REQ-020 SHALL register the write: wren_o=1, wrdata_o=FIFO p head, wraddress_o=BASE_ADDR+p*OUTPUT_SIZE+wr_count[p] (truncated to ADDR_WIDTH); wr_count[p] then increments.
REQ-021 SHALL give minimum latency of 1 cycle from the push edge to wren_o high for a word when p already points at that kernel.
REQ-022 SHALL allow a push and a pop on the same FIFO in the same cycle; occupancy stays unchanged and the push is never an overflow.
REQ-023 SHALL discard words for kernel k once wr_count[k]==OUTPUT_SIZE, popping without a write, so the address never exceeds its kernel region.
REQ-024 SHALL drive wren_o=0 in every cycle without a write; wrdata_o and wraddress_o hold their last value.
REQ-025 SHALL drive busy_o=1 in RUN only; done_o=1 on DONE entry and clears on start_i.
REQ-026 SHALL treat start_i during RUN as a restart: the REQ-014 clear applies and the FSM stays in RUN.

Reset
REQ-027 SHALL, while reset_ni=0, asynchronously force: state IDLE, FIFOs empty, counters 0, p=0, wren_o=0, wraddress_o=0, wrdata_o=0, hold_data_o all 1, busy_o=0, done_o=0, overflow_o=0.
REQ-028 SHALL abort a frame on reset mid-RUN with no further writes and require start_i to resume.

Verification (N_KERNELS=4, OUTPUT_SIZE=2, BASE_ADDR=0x10)
REQ-029 SHALL be verified for reset release then start_i: busy_o=1, hold_data_o=0000; valid on k0..k3 with values 0xA0..0xA3 -> writes at addrs 0x10,0x12,0x14,0x16 in order, one per cycle.
REQ-030 SHALL be verified for out-of-order arrival: valid k2 (0xC2) at cycle 1, then k0 (0xC0) at cycle 3 -> no write before cycle 4; writes are 0x10=0xC0, then 0x14=0xC2 only after k1 is written.
REQ-031 SHALL be verified for overflow: three back-to-back valids on k1 while p waits on k0 -> third word dropped, overflow_o=1, hold_data_o[1]=1 from cycle after the first push.
REQ-032 SHALL be verified for completion: 8 words across k0..k3 -> last write at 0x17, done_o=1, busy_o=0 next cycle; a 9th valid -> no write, no overflow.
REQ-033 SHALL be verified for reset mid-RUN after 3 writes: reset_ni low -> wren_o=0 immediately, all outputs at reset values; start_i then restarts at address 0x10.
REQ-034 SHALL be verified for simultaneous push/pop on a 1-entry FIFO at p: occupancy stays 1, overflow_o=0.
